// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into 32-bit words; the last byte is passed
// straight through so the word is available on the edge that accepts it.
module word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] hold_q, hold_d;

  always_comb begin
    lane_d = lane_q;
    hold_d = hold_q;
    if (clear_i) begin
      lane_d = '0;
      hold_d = '0;
    end else if (strobe_i) begin
      if (lane_q == LAST_LANE) begin
        lane_d = '0;
      end else begin
        hold_d[8*lane_q +: 8] = byte_i;
        lane_d                = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      hold_q <= '0;
    end else begin
      lane_q <= lane_d;
      hold_q <= hold_d;
    end
  end

  assign word_valid_o = strobe_i && !clear_i && (lane_q == LAST_LANE);
  assign word_o       = {byte_i, hold_q};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the imem write port, holding the CPU
// in reset while the load runs.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded,
  output state_e            state_dbg
);

  // Stream handshake: a byte moves on a rising edge where in_valid and in_ready
  // are both 1; in_ready depends only on state, never on in_valid.
  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d, err_q, err_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              xfer, pk_strobe, pk_clear, pk_valid;
  logic [31:0]       pk_word;
  logic [15:0]       hdr_len;

  word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (in_data),
    .strobe_i     (pk_strobe),
    .clear_i      (pk_clear),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign xfer     = in_valid && in_ready;
  assign hdr_len  = {in_data, len_q[7:0]};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pk_strobe = 1'b0;
    pk_clear  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LEN_LO;
          done_d   = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          pk_clear = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, in_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = hdr_len;
          if (hdr_len == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (hdr_len > 16'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        pk_strobe = xfer;
        if (pk_valid) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = pk_word;
          cnt_d   = cnt_q + 1'b1;
          if (16'(cnt_q) + 16'd1 == len_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = in_ready;
  assign cpu_hold     = in_ready;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives length-prefixed streams and checks
// imem writes, flags and handshake against hand-computed values.
module tb_imem_loader;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, err, cpu_hold;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  words_loaded;
  state_e      state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks (all begin and end on a falling edge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int bound;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    bound    = 0;
    while (!in_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 50) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_prog(input int max_gap);
    logic [7:0] prog [10];
    prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'hb0, 8'h00};
    for (int i = 0; i < 10; i++) send_byte(prog[i], $urandom_range(0, max_gap));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_write"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    // 1: two-word program, back-to-back
    pulse_start();
    check("t1_busy_start", 64'(busy), 64'd1);
    check("t1_hold_start", 64'(cpu_hold), 64'd1);
    exp_q.push_back({8'd0, 32'h00a00513});
    exp_q.push_back({8'd1, 32'h00b00593});
    send_prog(0);
    check("t1_we_last", 64'(mem_we), 64'd1);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_hold_end", 64'(cpu_hold), 64'd0);
    check("t1_words", 64'(words_loaded), 64'd2);
    @(negedge clk);
    check("t1_we_drop", 64'(mem_we), 64'd0);
    check("t1_addr_hold", 64'(mem_addr), 64'd1);
    check("t1_wdata_hold", 64'(mem_wdata), 64'h00b00593);
    check("t1_done_sticky", 64'(done), 64'd1);
    check_writes("t1");

    // 2: same program with random gaps
    pulse_start();
    check("t2_done_clr", 64'(done), 64'd0);
    exp_q.push_back({8'd0, 32'h00a00513});
    exp_q.push_back({8'd1, 32'h00b00593});
    send_prog(5);
    check("t2_done", 64'(done), 64'd1);
    check("t2_words", 64'(words_loaded), 64'd2);
    check("t2_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check_writes("t2");

    // 3: zero-length program
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t3_done", 64'(done), 64'd1);
    check("t3_words", 64'(words_loaded), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check_writes("t3");

    // 4: oversized header N=300
    pulse_start();
    send_byte(8'h2C, 0);
    send_byte(8'h01, 0);
    check("t4_err", 64'(err), 64'd1);
    check("t4_done", 64'(done), 64'd0);
    check("t4_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("t4_err_sticky", 64'(err), 64'd1);
    check("t4_ready_idle", 64'(in_ready), 64'd0);
    check_writes("t4");

    // 5: reset in the middle of word 1
    pulse_start();
    check("t5_err_clr", 64'(err), 64'd0);
    exp_q.push_back({8'd0, 32'h00a00513});
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'ha0, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("t5_rst");
    repeat (3) @(negedge clk);
    check_writes("t5_partial");
    pulse_start();
    exp_q.push_back({8'd0, 32'h12345678});
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_words", 64'(words_loaded), 64'd1);
    @(negedge clk);
    check_writes("t5_reload");

    // 6: start pulsed mid-load is ignored
    pulse_start();
    exp_q.push_back({8'd0, 32'h00a00513});
    exp_q.push_back({8'd1, 32'h00b00593});
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h05, 0);
    pulse_start();
    check("t6_busy_mid", 64'(busy), 64'd1);
    check("t6_words_mid", 64'(words_loaded), 64'd0);
    send_byte(8'ha0, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h05, 0); send_byte(8'hb0, 0); send_byte(8'h00, 0);
    check("t6_done", 64'(done), 64'd1);
    check("t6_words", 64'(words_loaded), 64'd2);
    @(negedge clk);
    check_writes("t6");
    pulse_start();
    check("t6_done_clr", 64'(done), 64'd0);
    check("t6_err_clr", 64'(err), 64'd0);
    check("t6_words_clr", 64'(words_loaded), 64'd0);
    check("t6_busy_restart", 64'(busy), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
